// File: rtl/decoder_scan_nto2n.sv
// Registered N-to-2^N one-hot decoder with direct (load) and scan modes.
// The scan index advances after a programmable dwell; wrap pulses once per full scan.
module decoder_scan_nto2n #(
    parameter int SEL_W   = 2,
    parameter int DWELL_W = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  mode,
    input  logic                  load,
    input  logic [SEL_W-1:0]      din,
    input  logic [DWELL_W-1:0]    dwell,
    output logic [2**SEL_W-1:0]   dout,
    output logic [SEL_W-1:0]      idx,
    output logic                  wrap
);

    localparam int OUT_W = 2**SEL_W;
    localparam logic [SEL_W-1:0] IDX_LAST = SEL_W'(OUT_W - 1);

    typedef enum logic {
        MODE_DIRECT = 1'b0,
        MODE_SCAN   = 1'b1
    } mode_e;

    logic [SEL_W-1:0]   idx_q, idx_d;
    logic [DWELL_W-1:0] cnt_q, cnt_d;
    logic [OUT_W-1:0]   dout_q, dout_d;
    logic               wrap_q, wrap_d;
    mode_e              mode_sel;

    assign mode_sel = mode_e'(mode);

    always_comb begin
        idx_d  = idx_q;
        cnt_d  = '0;
        wrap_d = 1'b0;

        if (en) begin
            case (mode_sel)
                MODE_DIRECT: begin
                    if (load) begin
                        idx_d = din;
                    end
                end
                MODE_SCAN: begin
                    // Load wins over an advance due in the same cycle; ">=" keeps a lowered dwell from stalling.
                    if (load) begin
                        idx_d = din;
                    end else if (cnt_q >= dwell) begin
                        idx_d  = idx_q + 1'b1;
                        wrap_d = (idx_q == IDX_LAST);
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                default: begin
                    idx_d = idx_q;
                end
            endcase
        end

        dout_d = '0;
        if (en) begin
            dout_d[idx_d] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idx_q  <= '0;
            cnt_q  <= '0;
            dout_q <= '0;
            wrap_q <= 1'b0;
        end else begin
            idx_q  <= idx_d;
            cnt_q  <= cnt_d;
            dout_q <= dout_d;
            wrap_q <= wrap_d;
        end
    end

    assign dout = dout_q;
    assign idx  = idx_q;
    assign wrap = wrap_q;

endmodule

// File: tb/tb_decoder_scan_nto2n.sv
// Directed bench for decoder_scan_nto2n: reset, direct loads, enable gating,
// scan timing with dwell changes, load during scan, reset mid-scan and mode switches.
module tb_decoder_scan_nto2n;

    logic       clk;
    logic       rst;
    logic       en;
    logic       mode;
    logic       load;
    logic [1:0] din;
    logic [7:0] dwell;
    logic [3:0] dout;
    logic [1:0] idx;
    logic       wrap;

    int tests_run;
    int tests_failed;

    decoder_scan_nto2n #(
        .SEL_W   (2),
        .DWELL_W (8)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .en    (en),
        .mode  (mode),
        .load  (load),
        .din   (din),
        .dwell (dwell),
        .dout  (dout),
        .idx   (idx),
        .wrap  (wrap)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one clock edge and settle just after it before sampling.
    task automatic applyStimulus(input int cycles);
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic checkState(input string tag, input logic [3:0] exp_dout,
                              input logic [1:0] exp_idx, input logic exp_wrap);
        checkOutput({tag, ".dout"}, 32'(dout), 32'(exp_dout));
        checkOutput({tag, ".idx"},  32'(idx),  32'(exp_idx));
        checkOutput({tag, ".wrap"}, 32'(wrap), 32'(exp_wrap));
    endtask

    logic [1:0] exp_idx;
    logic [3:0] exp_dout;
    int         wrap_count;

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst   = 1'b1;
        en    = 1'b1;
        mode  = 1'b0;
        load  = 1'b0;
        din   = 2'd0;
        dwell = 8'd0;

        // 1. Reset, then direct loads
        applyStimulus(2);
        checkState("reset", 4'b0000, 2'd0, 1'b0);
        rst  = 1'b0;
        load = 1'b1;
        din  = 2'd2;
        applyStimulus(1);
        checkState("load2", 4'b0100, 2'd2, 1'b0);
        load = 1'b0;
        applyStimulus(2);
        checkState("hold2", 4'b0100, 2'd2, 1'b0);
        din  = 2'd3;
        load = 1'b1;
        applyStimulus(1);
        checkState("load3", 4'b1000, 2'd3, 1'b0);
        din = 2'd2;
        applyStimulus(1);
        load = 1'b0;
        checkState("reload2", 4'b0100, 2'd2, 1'b0);

        // 2. Enable gating ignores load and holds idx
        en   = 1'b0;
        load = 1'b1;
        din  = 2'd1;
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1);
            checkState("en_off", 4'b0000, 2'd2, 1'b0);
        end
        en   = 1'b1;
        load = 1'b0;
        applyStimulus(1);
        checkState("en_on", 4'b0100, 2'd2, 1'b0);

        // 3. Scan with dwell=0 from idx=0
        din  = 2'd0;
        load = 1'b1;
        applyStimulus(1);
        load = 1'b0;
        checkState("direct0", 4'b0001, 2'd0, 1'b0);
        mode  = 1'b1;
        dwell = 8'd0;
        wrap_count = 0;
        for (int k = 1; k <= 8; k++) begin
            applyStimulus(1);
            exp_idx  = 2'(k);
            exp_dout = 4'b0001 << exp_idx;
            checkState("scan_d0", exp_dout, exp_idx, (exp_idx == 2'd0));
            if (wrap) wrap_count++;
        end
        checkOutput("scan_d0.wraps", 32'(wrap_count), 32'd2);

        // 4. Scan with dwell=2: each line 3 cycles, 12-cycle period
        dwell = 8'd2;
        wrap_count = 0;
        for (int k = 1; k <= 12; k++) begin
            applyStimulus(1);
            exp_idx  = 2'(k / 3);
            exp_dout = 4'b0001 << exp_idx;
            checkState("scan_d2", exp_dout, exp_idx, (k == 12));
            if (wrap) wrap_count++;
        end
        checkOutput("scan_d2.wraps", 32'(wrap_count), 32'd1);
        applyStimulus(2);
        checkState("scan_d2.mid", 4'b0001, 2'd0, 1'b0);
        dwell = 8'd0;
        applyStimulus(1);
        checkState("dwell_lower", 4'b0010, 2'd1, 1'b0);

        // 5. Load overrides a due advance
        dwell = 8'd3;
        applyStimulus(3);
        checkState("pre_load", 4'b0010, 2'd1, 1'b0);
        load = 1'b1;
        din  = 2'd0;
        applyStimulus(1);
        load = 1'b0;
        checkState("scan_load", 4'b0001, 2'd0, 1'b0);
        applyStimulus(3);
        checkState("scan_load.hold", 4'b0001, 2'd0, 1'b0);
        applyStimulus(1);
        checkState("scan_load.adv", 4'b0010, 2'd1, 1'b0);

        // 6. Reset mid-scan, then mode switches
        dwell = 8'd0;
        applyStimulus(2);
        checkState("to_idx3", 4'b1000, 2'd3, 1'b0);
        rst = 1'b1;
        applyStimulus(1);
        checkState("rst_mid", 4'b0000, 2'd0, 1'b0);
        rst = 1'b0;
        applyStimulus(2);
        checkState("rescan2", 4'b0100, 2'd2, 1'b0);
        mode = 1'b0;
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1);
            checkState("frozen", 4'b0100, 2'd2, 1'b0);
        end
        mode  = 1'b1;
        dwell = 8'd1;
        applyStimulus(1);
        checkState("resume.c1", 4'b0100, 2'd2, 1'b0);
        applyStimulus(1);
        checkState("resume.c2", 4'b1000, 2'd3, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
